// File: rtl/libstf_pkg.sv
// Shared helpers and types for the stream compaction / width conversion blocks.
package libstf_pkg;

  localparam int unsigned MAX_LANES = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Number of set bits in a lane mask (callers zero-extend to MAX_LANES).
  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

  // Thermometer mask with the low n bits set, n in 0..MAX_LANES.
  function automatic logic [MAX_LANES-1:0] therm_mask(input int unsigned n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/lane_packer.sv
// Packs keep-selected input lanes contiguously after cnt buffered elements.
module lane_packer #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 32
) (
  input  logic [N*DW-1:0]       data_i,
  input  logic [N-1:0]          keep_i,
  input  logic [(N-1)*DW-1:0]   acc_i,
  input  logic [$clog2(N)-1:0]  cnt_i,
  output logic [(2*N-1)*DW-1:0] comb_o
);

  // Buffered elements occupy slots 0..cnt-1; kept lanes follow in lane order.
  always_comb begin
    int unsigned pos;
    comb_o = '0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (i < 32'(cnt_i)) begin
        comb_o[i*DW +: DW] = acc_i[i*DW +: DW];
      end
    end
    pos = 32'(cnt_i);
    for (int unsigned j = 0; j < N; j++) begin
      if (keep_i[j]) begin
        comb_o[pos*DW +: DW] = data_i[j*DW +: DW];
        pos = pos + 1;
      end
    end
  end

endmodule

// File: rtl/ndata_compactor.sv
// Compacts sparse keep-qualified beats into dense beats, preserving order.
module ndata_compactor
  import libstf_pkg::*;
#(
  parameter type         data_t       = logic [31:0],
  parameter int unsigned NUM_ELEMENTS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_ELEMENTS*$bits(data_t)-1:0] in_data,
  input  logic [NUM_ELEMENTS-1:0]              in_keep,
  input  logic                                 in_last,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NUM_ELEMENTS*$bits(data_t)-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0]              out_keep,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int unsigned N  = NUM_ELEMENTS;
  localparam int unsigned DW = $bits(data_t);
  localparam int unsigned BW = N * DW;
  localparam int unsigned AW = (N - 1) * DW;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] N_S = SW'(N);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [BW-1:0]         out_data_q, out_data_d;
  logic [N-1:0]          out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [(2*N-1)*DW-1:0] comb;
  logic [SW-1:0]         sum;
  logic                  slot_free;

  lane_packer #(
    .N  (N),
    .DW (DW)
  ) u_lane_packer (
    .data_i (in_data),
    .keep_i (in_keep),
    .acc_i  (acc_q),
    .cnt_i  (cnt_q),
    .comb_o (comb)
  );

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  // Next-state, accumulator update and output beat loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    slot_free   = !out_valid_q || out_ready;
    sum         = SW'(cnt_q) + SW'(popcount(MAX_LANES'(in_keep)));

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          if (sum > N_S || (sum == N_S && !in_last)) begin
            // Full beat out; overflow stays buffered (and is flushed if last).
            out_data_d  = comb[0 +: BW];
            out_keep_d  = '1;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            acc_d       = comb[BW +: AW];
            cnt_d       = CW'(sum - N_S);
            if (in_last) begin
              state_d = FLUSH;
            end
          end else if (in_last) begin
            // Whole remainder fits; an empty beat still carries last.
            out_data_d  = comb[0 +: BW];
            out_keep_d  = N'(therm_mask(32'(sum)));
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            acc_d = comb[0 +: AW];
            cnt_d = CW'(sum);
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_data_d  = BW'(acc_q);
          out_keep_d  = N'(therm_mask(32'(cnt_q)));
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, accumulator and output beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/ndata_compactor.md
Name: ndata_compactor

Overview:
- Stream compactor directly downstream of the dictionary stage. Consumes its sparse ndata output: NUM_ELEMENTS lanes, per-lane keep, last.
- Emits dense beats: every non-final beat has all lanes valid; the final beat of a stream carries the remainder in the low lanes.
- Preserves element order: buffered elements first, then lane 0 upward.
- Lets downstream writers (memory sinks, width converters) assume contiguous keep.

Parameters:
- data_t, logic[31:0], element type carried per lane.
- NUM_ELEMENTS, 8, lanes per beat; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_ELEMENTS*$bits(data_t)  input lanes.
- in_keep  in  NUM_ELEMENTS  per-lane element valid; any pattern allowed.
- in_last  in  1  final beat of stream.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_data  out  NUM_ELEMENTS*$bits(data_t)  compacted lanes.
- out_keep  out  NUM_ELEMENTS  thermometer code; low bits set.
- out_last  out  1  final beat of stream.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - out_valid=0, out_keep=0, out_last=0, out_data=0.
  - Accumulator count cnt=0; state=RUN.
  - in_ready is 1 after reset.
- Internal storage:
  - Accumulator acc of NUM_ELEMENTS-1 entries.
  - cnt of width $clog2(NUM_ELEMENTS); range 0..NUM_ELEMENTS-1.
  - One registered output beat.
- Per accepted beat:
  - k = popcount(in_keep).
  - Kept elements are packed by prefix-sum of in_keep and appended after acc[0..cnt-1].
  - sum = cnt + k, computed in $clog2(NUM_ELEMENTS)+2 bits.
- State RUN:
  - in_ready = !out_valid || out_ready.
  - On accept with !in_last:
    - sum >= N: load out with the first N combined elements, out_keep all ones, out_last=0. Remaining sum-N elements go to acc, cnt=sum-N.
    - sum < N: no output; acc and cnt update; out_valid falls if the old beat was taken.
  - On accept with in_last:
    - sum <= N: emit one beat with keep=(1<<sum)-1 and out_last=1; cnt=0.
    - sum == 0: emit keep=0, last=1 so that last is never dropped.
    - sum > N: emit full beat with last=0; store remainder; go to FLUSH.
- State FLUSH:
  - in_ready=0.
  - When the output slot frees, emit the acc remainder with keep=(1<<cnt)-1 and last=1.
  - Then cnt=0 and return to RUN.
- Latency: 1 cycle from accepting a completing input beat to out_valid.
- Throughput: one beat per cycle except one bubble per stream when FLUSH is entered.
- Output beat is held stable while out_valid && !out_ready (AXI-style). out_valid never drops without a handshake.
- Simultaneous handshakes:
  - Output consumed and new beat accepted in the same cycle: the new result replaces the old one with no bubble.
  - Input beat with keep=0 and !last: accepted, no state change.
- Reset mid-stream: partial acc content is discarded and no output is produced.
- Ordering across streams: the next stream's elements never share a beat with the previous stream's last beat.

Decomposition:
- Shared package (libstf_pkg) holds:
  - popcount function.
  - thermometer-mask function: (1<<n)-1 for n in 0..N.
  - state enum {RUN, FLUSH}.
- Sub-module lane_packer: combinational prefix-sum plus mux. Places the in_keep-selected lanes contiguously at offset cnt into a 2N-1 wide combined vector. Reusable by the width converters.

Test Plan (N=4, 32-bit data):
- Dense pass-through: beats {0,1,2,3} keep=1111, {4,5,6,7} keep=1111 last → two beats, same data; second last=1; 1-cycle latency.
- Sparse merge: keep=0101 data{A,B,C,D}, then keep=1011 data{E,F,G,H}, then keep=0001 {I} last → beat {A,C,E,F} keep=1111, then {H,I} keep=0011 last=1.
- Flush overflow: cnt=3 buffered {X,Y,Z}, last beat keep=1111 {P,Q,R,S} → {X,Y,Z,P} last=0, then FLUSH with in_ready=0, then {Q,R,S} keep=0111 last=1, then in_ready=1.
- Empty last: single beat keep=0000 last=1 → one output beat keep=0000 last=1.
- Backpressure: out_ready low 5 cycles with a full beat pending → out_data/out_keep stable, in_ready=0, no input lost. Random out_ready over 1000 random-keep beats matches the reference model order.
- Reset mid-stream: cnt=2, assert rst_n low → out_valid=0 immediately. After release, new stream {1,2,3,4} last → exactly {1,2,3,4} with no stale elements.
